// File: rtl/sa_decimate_sequencer_pkg.sv
// Shared types and helpers for the SA decimate sequencer and its watchdog.
package sa_decimate_sequencer_pkg;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    WAIT_SYNC = 2'd1,
    RUN       = 2'd2
  } seqState_t;

  // Bits needed to count 0..value-1; never less than one bit.
  function automatic int clog2(input int value);
    int result;
    result = 0;
    for (int i = 0; i < 31; i++) begin
      if ((1 << i) < value) result = i + 1;
    end
    return (result < 1) ? 1 : result;
  endfunction

endpackage

// File: rtl/sa_decimate_sequencer_if.sv
// Sample-in / CIC-out bundle between the FA source, the sequencer and the SA decimator.
interface sa_decimate_sequencer_if #(
  parameter int DATA_WIDTH    = 32,
  parameter int CHANNEL_COUNT = 4
);
  logic                                sampleValid;
  logic [CHANNEL_COUNT*DATA_WIDTH-1:0] sampleData;
  logic                                syncMarker;
  logic [CHANNEL_COUNT*DATA_WIDTH-1:0] cicData;
  logic                                cicToggle;
  logic                                cicDecimateFlag;
  logic                                saToggle;

  // Source/decimator side: provides samples and the decimator output toggle.
  modport master (
    output sampleValid, sampleData, syncMarker, saToggle,
    input  cicData, cicToggle, cicDecimateFlag
  );

  // Sequencer side.
  modport slave (
    input  sampleValid, sampleData, syncMarker, saToggle,
    output cicData, cicToggle, cicDecimateFlag
  );
endinterface

// File: rtl/sa_decimate_sequencer_watchdog.sv
// Countdown watchdog: load arms it with TIMEOUT, a toggle change or clear disarms it,
// and expire pulses for one cycle when the count runs out while still armed.
module sa_watchdog
  import sa_decimate_sequencer_pkg::*;
#(
  parameter int TIMEOUT = 64
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clear,
  input  logic load,
  input  logic toggleChanged,
  output logic expire
);

  localparam int COUNT_WIDTH = clog2(TIMEOUT + 1);

  logic [COUNT_WIDTH-1:0] count;
  logic                   armed;

  // Last cycle of the countdown with nothing rescuing it; a reload or a toggle change wins.
  assign expire = armed && !clear && !load && !toggleChanged && (count == COUNT_WIDTH'(1));

  // Arm, reload, disarm and count down.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      armed <= 1'b0;
      count <= '0;
    end else if (clear) begin
      armed <= 1'b0;
      count <= '0;
    end else if (load) begin
      armed <= 1'b1;
      count <= COUNT_WIDTH'(TIMEOUT);
    end else if (armed) begin
      if (toggleChanged || count == COUNT_WIDTH'(1)) begin
        armed <= 1'b0;
        count <= '0;
      end else begin
        count <= count - COUNT_WIDTH'(1);
      end
    end
  end

endmodule

// File: rtl/sa_decimate_sequencer.sv
// Paces the SA CIC decimator: forwards FA samples as a toggle/data/flag handshake,
// aligns the decimation phase to the sync marker and watches for missing SA outputs.
module sa_decimate_sequencer
  import sa_decimate_sequencer_pkg::*;
#(
  parameter int DATA_WIDTH        = 32,
  parameter int CHANNEL_COUNT     = 4,
  parameter int DECIMATION_FACTOR = 1000,
  parameter int TIMEOUT           = 64,
  localparam int PHASE_WIDTH      = clog2(DECIMATION_FACTOR)
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   enable,
  input  logic                   errClear,
  sa_decimate_sequencer_if.slave bus,
  output logic [PHASE_WIDTH-1:0] phase,
  output logic                   running,
  output logic                   syncErr,
  output logic                   saTimeout
);

  localparam logic [PHASE_WIDTH-1:0] LAST_PHASE = PHASE_WIDTH'(DECIMATION_FACTOR - 1);

  seqState_t                           state;
  logic [CHANNEL_COUNT*DATA_WIDTH-1:0] cicDataReg;
  logic                                cicToggleReg;
  logic                                cicFlagReg;
  logic                                markerArmed;
  logic                                saToggleRef;
  logic                                markerSeen;
  logic                                forwardSample;
  logic                                realign;
  logic                                flagNext;
  logic                                syncErrSet;
  logic                                wdExpire;

  assign bus.cicData         = cicDataReg;
  assign bus.cicToggle       = cicToggleReg;
  assign bus.cicDecimateFlag = cicFlagReg;

  // Decide whether this cycle's sample is forwarded, and whether it restarts the phase.
  always_comb begin
    markerSeen    = markerArmed | bus.syncMarker;
    forwardSample = 1'b0;
    if (enable && bus.sampleValid) begin
      if (state == WAIT_SYNC) forwardSample = markerSeen;
      else if (state == RUN)  forwardSample = 1'b1;
    end
    realign    = forwardSample && markerSeen;
    flagNext   = forwardSample && !realign && (phase == LAST_PHASE);
    syncErrSet = realign && (state == RUN) && (phase != '0);
  end

  // Sequencer FSM with the phase counter, marker arm and forwarded-data register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= IDLE;
      running      <= 1'b0;
      phase        <= '0;
      markerArmed  <= 1'b0;
      cicDataReg   <= '0;
      cicToggleReg <= 1'b0;
      cicFlagReg   <= 1'b0;
    end else if (!enable) begin
      state       <= IDLE;
      running     <= 1'b0;
      phase       <= '0;
      markerArmed <= 1'b0;
    end else begin
      case (state)
        IDLE:      state <= WAIT_SYNC;
        WAIT_SYNC: if (forwardSample) begin
                     state   <= RUN;
                     running <= 1'b1;
                   end
        default:   ;
      endcase
      if (forwardSample) begin
        cicDataReg   <= bus.sampleData;
        cicToggleReg <= ~cicToggleReg;
        cicFlagReg   <= flagNext;
        markerArmed  <= 1'b0;
        // A realigned sample is phase 0, so the counter moves on to 1.
        if (realign)                  phase <= PHASE_WIDTH'(1);
        else if (phase == LAST_PHASE) phase <= '0;
        else                          phase <= phase + PHASE_WIDTH'(1);
      end else if (bus.syncMarker && state != IDLE) begin
        markerArmed <= 1'b1;
      end
    end
  end

  // Sticky error flags (a set beats a same-cycle clear) and the saToggle reference copy.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      syncErr     <= 1'b0;
      saTimeout   <= 1'b0;
      saToggleRef <= 1'b0;
    end else begin
      syncErr     <= syncErrSet | (syncErr & ~errClear);
      saTimeout   <= wdExpire | (saTimeout & ~errClear);
      saToggleRef <= bus.saToggle;
    end
  end

  sa_watchdog #(
    .TIMEOUT(TIMEOUT)
  ) uWatchdog (
    .clk          (clk),
    .rst_n        (rst_n),
    .clear        (!enable),
    .load         (forwardSample && flagNext),
    .toggleChanged(bus.saToggle != saToggleRef),
    .expire       (wdExpire)
  );

endmodule
